// File: rtl/spart_tx_arb_if.sv
// rtl/spart_tx_arb_if.sv - requester, transmitter and status signals of the SPART transmit arbiter
interface spart_tx_arb_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_en;
  logic [7:0]        tx_data;
  logic              tx_tbr;
  logic              busy;
  logic              ack_err;
  logic              err_clr;

  modport master (
    output req_valid, req_data, req_last, tx_tbr, err_clr,
    input  req_ready, grant, tx_en, tx_data, busy, ack_err
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_tbr, err_clr,
    output req_ready, grant, tx_en, tx_data, busy, ack_err
  );
endinterface

// File: rtl/spart_tx_arb.sv
// rtl/spart_tx_arb.sv - round-robin arbiter sharing one SPART transmitter among NREQ byte producers
module spart_tx_arb #(
  parameter int NREQ         = 4,
  parameter int ACK_TIMEOUT  = 8,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic          clk,
  input logic          rst,
  spart_tx_arb_if.slave bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int LW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ARB,
    ISSUE,
    WAIT_START,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t          state, state_nxt;
  logic [IW-1:0]   rr_ptr, rr_ptr_nxt;
  logic [IW-1:0]   owner, owner_nxt;
  logic            lock, lock_nxt;
  logic [NREQ-1:0] grant_q, grant_nxt;
  logic [7:0]      tx_data_q, tx_data_nxt;
  logic            ack_err_q, ack_err_nxt;
  logic [AW-1:0]   ack_cnt, ack_cnt_nxt;
  logic [LW-1:0]   idle_cnt, idle_cnt_nxt;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic            do_accept;
  logic [IW-1:0]   acc_idx;
  logic            ack_set;
  logic            tx_en_c;
  logic [NREQ-1:0] ready_c;

  // Round-robin search starting just after the last released owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    lock_nxt     = lock;
    grant_nxt    = grant_q;
    tx_data_nxt  = tx_data_q;
    ack_cnt_nxt  = ack_cnt;
    idle_cnt_nxt = idle_cnt;
    ack_set      = 1'b0;
    tx_en_c      = 1'b0;
    do_accept    = 1'b0;
    acc_idx      = owner;
    ready_c      = '0;

    case (state)
      ARB: begin
        if (bus.tx_tbr && win_found) begin
          do_accept = 1'b1;
          acc_idx   = win_idx;
        end
      end

      ISSUE: begin
        tx_en_c     = 1'b1;
        ack_cnt_nxt = '0;
        state_nxt   = WAIT_START;
      end

      // ack_cnt counts WAIT_START cycles; giving up on the (ACK_TIMEOUT-1)th
      // makes ack_err visible ACK_TIMEOUT cycles after the tx_en cycle.
      WAIT_START: begin
        if (!bus.tx_tbr) begin
          state_nxt = WAIT_DONE;
        end else if (ack_cnt >= AW'(ACK_TIMEOUT - 2)) begin
          ack_set    = 1'b1;
          lock_nxt   = 1'b0;
          grant_nxt  = '0;
          rr_ptr_nxt = owner;
          state_nxt  = ARB;
        end else begin
          ack_cnt_nxt = ack_cnt + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (bus.tx_tbr) begin
          if (lock) begin
            idle_cnt_nxt = '0;
            state_nxt    = HOLD;
          end else begin
            grant_nxt  = '0;
            rr_ptr_nxt = owner;
            state_nxt  = ARB;
          end
        end
      end

      HOLD: begin
        if (bus.req_valid[owner]) begin
          do_accept = 1'b1;
          acc_idx   = owner;
        end else if (idle_cnt >= LW'(LOCK_TIMEOUT - 1)) begin
          lock_nxt   = 1'b0;
          grant_nxt  = '0;
          rr_ptr_nxt = owner;
          state_nxt  = ARB;
        end else begin
          idle_cnt_nxt = idle_cnt + 1'b1;
        end
      end

      default: state_nxt = ARB;
    endcase

    // Never hand out req_ready during reset: the requester would drop a byte
    // the arbiter is about to forget.
    if (do_accept && !rst) begin
      ready_c      = {{(NREQ-1){1'b0}}, 1'b1} << acc_idx;
      grant_nxt    = {{(NREQ-1){1'b0}}, 1'b1} << acc_idx;
      owner_nxt    = acc_idx;
      tx_data_nxt  = bus.req_data[{acc_idx, 3'b000} +: 8];
      lock_nxt     = ~bus.req_last[acc_idx];
      idle_cnt_nxt = '0;
      state_nxt    = ISSUE;
    end

    if (ack_set)
      ack_err_nxt = 1'b1;
    else if (bus.err_clr)
      ack_err_nxt = 1'b0;
    else
      ack_err_nxt = ack_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      rr_ptr    <= IW'(NREQ - 1);
      owner     <= '0;
      lock      <= 1'b0;
      grant_q   <= '0;
      tx_data_q <= 8'h00;
      ack_err_q <= 1'b0;
      ack_cnt   <= '0;
      idle_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      rr_ptr    <= rr_ptr_nxt;
      owner     <= owner_nxt;
      lock      <= lock_nxt;
      grant_q   <= grant_nxt;
      tx_data_q <= tx_data_nxt;
      ack_err_q <= ack_err_nxt;
      ack_cnt   <= ack_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.grant     = grant_q;
  assign bus.tx_en     = tx_en_c;
  assign bus.tx_data   = tx_data_q;
  assign bus.busy      = (state != ARB);
  assign bus.ack_err   = ack_err_q;

endmodule
